// File: rtl/sample_window_capture14.sv
`default_nettype none
// ============================================================================
// Module  : sample_window_capture14
// Brief   : Armed/triggered capture of LENGTH 14-bit samples into distributed
//           RAM, then AXI-Stream style readout. Optional dropped-trigger
//           counter enabled by macro SAMPLE_WINDOW_CAPTURE14_DROP_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module sample_window_capture14 #(
    parameter int LENGTH = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [13:0] dat_i,
    input  logic        arm_i,
    input  logic        trig_i,
    output logic        armed_o,
    output logic        busy_o,
    output logic [13:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast
`ifdef SAMPLE_WINDOW_CAPTURE14_DROP_CNT_EN
    ,
    output logic [7:0]  drop_cnt_o
`endif
);

    localparam int              c_AW   = $clog2(LENGTH);
    localparam logic [c_AW-1:0] c_LAST = c_AW'(LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_READOUT = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_armed;
    logic            r_busy;
    logic [c_AW-1:0] r_wr_addr;
    logic [c_AW-1:0] r_rd_addr;
    logic [13:0]     r_tdata;
    logic            r_tvalid;
    logic            r_tlast;
    logic [13:0]     r_mem [LENGTH];
    logic            w_we;

    assign w_we = !rst_i && (((r_state == S_ARMED) && trig_i) || (r_state == S_CAPTURE));

    // RAM is deliberately not reset; only the address pointers are.
    always_ff @(posedge clk_i) begin
        if (w_we) begin
            r_mem[r_wr_addr] <= dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_armed   <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arm_i) begin
                        r_state <= S_ARMED;
                        r_armed <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (trig_i) begin
                        r_state   <= S_CAPTURE;
                        r_armed   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_wr_addr <= r_wr_addr + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_wr_addr <= r_wr_addr + 1'b1;
                    if (r_wr_addr == c_LAST) begin
                        r_state <= S_READOUT;
                    end
                end
                S_READOUT: begin
                    // Output register refills whenever empty or being accepted,
                    // giving one word per clock with no bubbles.
                    if (r_tvalid && m_tready && r_tlast) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                    end else if (!r_tvalid || m_tready) begin
                        r_tdata   <= r_mem[r_rd_addr];
                        r_tvalid  <= 1'b1;
                        r_tlast   <= (r_rd_addr == c_LAST);
                        r_rd_addr <= r_rd_addr + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign armed_o  = r_armed;
    assign busy_o   = r_busy;
    assign m_tdata  = r_tdata;
    assign m_tvalid = r_tvalid;
    assign m_tlast  = r_tlast;

`ifdef SAMPLE_WINDOW_CAPTURE14_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_drop_cnt <= '0;
        end else if (trig_i && ((r_state == S_CAPTURE) || (r_state == S_READOUT))
                     && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt_o = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sample_window_capture14.sv
`default_nettype none
// ============================================================================
// Module  : tb_sample_window_capture14
// Brief   : Directed self-checking bench for sample_window_capture14, LENGTH=8,
//           dat_i = 14'h0100 + cycle index.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sample_window_capture14;

    localparam int LENGTH = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [13:0] dat_i;
    logic        arm_i;
    logic        trig_i;
    logic        armed_o;
    logic        busy_o;
    logic [13:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
`ifdef SAMPLE_WINDOW_CAPTURE14_DROP_CNT_EN
    logic [7:0]  drop_cnt_o;
`endif

    int unsigned cyc;
    int          tests = 0;
    int          fails = 0;
    logic [13:0] got [LENGTH];
    logic        tl  [LENGTH];
    int          got_n;
    int          first_lat;

    always #5 clk_i = ~clk_i;

    sample_window_capture14 #(.LENGTH(LENGTH)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .dat_i     (dat_i),
        .arm_i     (arm_i),
        .trig_i    (trig_i),
        .armed_o   (armed_o),
        .busy_o    (busy_o),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast)
`ifdef SAMPLE_WINDOW_CAPTURE14_DROP_CNT_EN
        ,
        .drop_cnt_o(drop_cnt_o)
`endif
    );

    // Sample stream: value tracks the clock index.
    initial begin
        cyc   = 0;
        dat_i = 14'h0100;
        forever begin
            @(posedge clk_i);
            #1;
            cyc   = cyc + 1;
            dat_i = 14'h0100 + cyc[13:0];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk_i);
        #2;
    endtask

    // Collects one window with m_tready=1; i=0 is the cycle after the trigger.
    task automatic drain;
        m_tready  = 1'b1;
        got_n     = 0;
        first_lat = -1;
        for (int i = 0; i < 40 && got_n < LENGTH; i++) begin
            if (m_tvalid) begin
                if (first_lat < 0) first_lat = i;
                got[got_n] = m_tdata;
                tl[got_n]  = m_tlast;
                got_n++;
            end
            step();
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1; arm_i = 1'b0; trig_i = 1'b0; m_tready = 1'b1;
        step(); step();
        tests++;
        if ({armed_o, busy_o, m_tvalid, m_tlast} !== 4'b0000 || m_tdata !== 14'h0)
            $display("FAIL reset_outputs: got armed=%b busy=%b tvalid=%b tlast=%b tdata=%h required all 0",
                     armed_o, busy_o, m_tvalid, m_tlast, m_tdata);
`ifdef SAMPLE_WINDOW_CAPTURE14_DROP_CNT_EN
        tests++;
        if (drop_cnt_o !== 8'd0) begin
            fails++; $display("FAIL reset_drop_cnt: got %0d required 0", drop_cnt_o);
        end
`endif
        if ({armed_o, busy_o, m_tvalid, m_tlast} !== 4'b0000 || m_tdata !== 14'h0) fails++;
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_basic;
        logic [13:0] base;
        int          w;
        w = 0;
        while (dat_i !== 14'h011F && w < 200) begin step(); w++; end
        arm_i = 1'b1; step(); arm_i = 1'b0;
        tests++;
        if (armed_o !== 1'b1) begin fails++; $display("FAIL basic_armed: got %b required 1", armed_o); end
        base = dat_i;
        tests++;
        if (base !== 14'h0120) begin fails++; $display("FAIL basic_trig_data: got %h required 0120", base); end
        trig_i = 1'b1; step(); trig_i = 1'b0;
        tests++;
        if (busy_o !== 1'b1 || armed_o !== 1'b0) begin
            fails++; $display("FAIL basic_busy: got busy=%b armed=%b required 1 0", busy_o, armed_o);
        end
        drain();
        tests++;
        if (first_lat !== 8) begin fails++; $display("FAIL basic_latency: tvalid at T+%0d required T+9", first_lat + 1); end
        tests++;
        if (got_n !== LENGTH) begin fails++; $display("FAIL basic_count: got %0d required 8", got_n); end
        for (int k = 0; k < LENGTH; k++) begin
            tests++;
            if (got[k] !== 14'h0120 + 14'(k) || tl[k] !== (k == LENGTH - 1)) begin
                fails++;
                $display("FAIL basic_word%0d: got %h last=%b required %h last=%b",
                         k, got[k], tl[k], 14'h0120 + 14'(k), (k == LENGTH - 1));
            end
        end
        tests++;
        if (m_tvalid !== 1'b0 || busy_o !== 1'b0 || armed_o !== 1'b0) begin
            fails++; $display("FAIL basic_idle_T17: got tvalid=%b busy=%b armed=%b required 0 0 0",
                              m_tvalid, busy_o, armed_o);
        end
    endtask

    task automatic test_stall;
        logic [13:0] base, hd;
        logic        hl, held_v, tog;
        int          idx;
        arm_i = 1'b1; step(); arm_i = 1'b0;
        base = dat_i; trig_i = 1'b1; step(); trig_i = 1'b0;
        arm_i = 1'b1; step(); arm_i = 1'b0;
        idx = 0; held_v = 1'b0; tog = 1'b1; hd = '0; hl = 1'b0;
        for (int i = 0; i < 60 && idx < LENGTH; i++) begin
            if (held_v) begin
                tests++;
                if (m_tvalid !== 1'b1 || m_tdata !== hd || m_tlast !== hl) begin
                    fails++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                             m_tvalid, m_tdata, m_tlast, hd, hl);
                end
            end
            if (m_tvalid) begin
                m_tready = tog; tog = !tog;
                if (m_tready) begin
                    tests++;
                    if (m_tdata !== base + 14'(idx) || m_tlast !== (idx == LENGTH - 1)) begin
                        fails++;
                        $display("FAIL stall_word%0d: got %h last=%b required %h last=%b",
                                 idx, m_tdata, m_tlast, base + 14'(idx), (idx == LENGTH - 1));
                    end
                    idx++; held_v = 1'b0;
                end else begin
                    held_v = 1'b1; hd = m_tdata; hl = m_tlast;
                end
            end else begin
                m_tready = 1'b0;
            end
            step();
        end
        m_tready = 1'b1;
        tests++;
        if (idx !== LENGTH) begin fails++; $display("FAIL stall_count: got %0d required 8", idx); end
        tests++;
        if (m_tvalid !== 1'b0 || armed_o !== 1'b0) begin
            fails++; $display("FAIL stall_end: got tvalid=%b armed=%b required 0 0", m_tvalid, armed_o);
        end
    endtask

    task automatic test_arm_trig;
        logic [13:0] base;
        trig_i = 1'b1; step(); trig_i = 1'b0;
        tests++;
        if (armed_o !== 1'b0 || busy_o !== 1'b0) begin
            fails++; $display("FAIL idle_trig: got armed=%b busy=%b required 0 0", armed_o, busy_o);
        end
        arm_i = 1'b1; trig_i = 1'b1; step(); arm_i = 1'b0; trig_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (armed_o !== 1'b1 || busy_o !== 1'b0) begin
                fails++; $display("FAIL armed_wait%0d: got armed=%b busy=%b required 1 0", k, armed_o, busy_o);
            end
            if (k < 2) step();
        end
        base = dat_i; trig_i = 1'b1; step(); trig_i = 1'b0;
        drain();
        tests++;
        if (got_n !== LENGTH || first_lat !== 8) begin
            fails++; $display("FAIL late_trig_window: got n=%0d lat=%0d required n=8 lat=8", got_n, first_lat);
        end
        for (int k = 0; k < LENGTH; k++) begin
            tests++;
            if (got[k] !== base + 14'(k)) begin
                fails++; $display("FAIL late_trig_word%0d: got %h required %h", k, got[k], base + 14'(k));
            end
        end
    endtask

    task automatic test_reset_midcapture;
        logic [13:0] base;
        int          hi;
        arm_i = 1'b1; step(); arm_i = 1'b0;
        trig_i = 1'b1; step(); trig_i = 1'b0;
        step(); step(); step();
        rst_i = 1'b1; step(); rst_i = 1'b0;
        tests++;
        if ({armed_o, busy_o, m_tvalid, m_tlast} !== 4'b0000 || m_tdata !== 14'h0) begin
            fails++; $display("FAIL midcap_reset: got armed=%b busy=%b v=%b l=%b d=%h required all 0",
                              armed_o, busy_o, m_tvalid, m_tlast, m_tdata);
        end
        hi = 0;
        for (int k = 0; k < 12; k++) begin if (m_tvalid) hi++; step(); end
        tests++;
        if (hi !== 0) begin fails++; $display("FAIL midcap_quiet: got %0d valid cycles required 0", hi); end
        arm_i = 1'b1; step(); arm_i = 1'b0;
        base = dat_i; trig_i = 1'b1; step(); trig_i = 1'b0;
        drain();
        tests++;
        if (got_n !== LENGTH || first_lat !== 8) begin
            fails++; $display("FAIL midcap_rewindow: got n=%0d lat=%0d required n=8 lat=8", got_n, first_lat);
        end
        for (int k = 0; k < LENGTH; k++) begin
            tests++;
            if (got[k] !== base + 14'(k) || tl[k] !== (k == LENGTH - 1)) begin
                fails++; $display("FAIL midcap_word%0d: got %h required %h", k, got[k], base + 14'(k));
            end
        end
    endtask

    task automatic test_reset_midreadout;
        logic [13:0] base;
        arm_i = 1'b1; step(); arm_i = 1'b0;
        trig_i = 1'b1; step(); trig_i = 1'b0;
        m_tready = 1'b1;
        for (int k = 0; k < 10; k++) step();
        rst_i = 1'b1; step(); rst_i = 1'b0;
        tests++;
        if (m_tvalid !== 1'b0 || busy_o !== 1'b0) begin
            fails++; $display("FAIL midread_reset: got tvalid=%b busy=%b required 0 0", m_tvalid, busy_o);
        end
        arm_i = 1'b1; step(); arm_i = 1'b0;
        base = dat_i; trig_i = 1'b1; step(); trig_i = 1'b0;
        drain();
        tests++;
        if (got_n !== LENGTH || got[0] !== base || got[LENGTH-1] !== base + 14'(LENGTH - 1)) begin
            fails++; $display("FAIL midread_rewindow: got n=%0d first=%h last=%h required 8 %h %h",
                              got_n, got[0], got[LENGTH-1], base, base + 14'(LENGTH - 1));
        end
    endtask

`ifdef SAMPLE_WINDOW_CAPTURE14_DROP_CNT_EN
    task automatic test_drop_cnt;
        rst_i = 1'b1; step(); rst_i = 1'b0;
        m_tready = 1'b1; trig_i = 1'b1;
        for (int w = 0; w < 20; w++) begin
            arm_i = 1'b1; step(); arm_i = 1'b0;
            for (int k = 0; k < 17; k++) step();
            if (w == 0) begin
                tests++;
                if (drop_cnt_o !== 8'd16) begin fails++; $display("FAIL drop_first: got %0d required 16", drop_cnt_o); end
            end
            if (w == 18) begin
                tests++;
                if (drop_cnt_o !== 8'd255) begin fails++; $display("FAIL drop_sat: got %0d required 255", drop_cnt_o); end
            end
        end
        tests++;
        if (drop_cnt_o !== 8'd255) begin fails++; $display("FAIL drop_hold: got %0d required 255", drop_cnt_o); end
        trig_i = 1'b0;
        rst_i = 1'b1; step(); rst_i = 1'b0;
        tests++;
        if (drop_cnt_o !== 8'd0) begin fails++; $display("FAIL drop_clear: got %0d required 0", drop_cnt_o); end
    endtask
`endif

    initial begin
        rst_i = 1'b1; arm_i = 1'b0; trig_i = 1'b0; m_tready = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_arm_trig();
        test_reset_midcapture();
        test_reset_midreadout();
`ifdef SAMPLE_WINDOW_CAPTURE14_DROP_CNT_EN
        test_drop_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sample_window_capture14.md
SAMPLE_WINDOW_CAPTURE14 -- requirements
Module: sample_window_capture14

Interface
REQ-001 SHALL have parameter LENGTH, default 32, samples per capture window; legal values are powers of two from 4 to 64.
REQ-002 SHALL have port clk_i, input, 1, the single clock for all logic.
REQ-003 SHALL have port rst_i, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port dat_i, input, 14, the delayed sample stream, one sample per clk_i.
REQ-005 SHALL have port arm_i, input, 1, a single-cycle arm request.
REQ-006 SHALL have port trig_i, input, 1, a single-cycle trigger.
REQ-007 SHALL have port armed_o, output, 1, high while in ARMED.
REQ-008 SHALL have port busy_o, output, 1, high while in CAPTURE or READOUT.
REQ-009 SHALL have port m_tdata, output, 14, the captured sample being read out.
REQ-010 SHALL have port m_tvalid, output, 1, the readout valid.
REQ-011 SHALL have port m_tready, input, 1, the readout ready.
REQ-012 SHALL have port m_tlast, output, 1, high with the final sample of a window.
REQ-013 SHALL have port drop_cnt_o, output, 8, the dropped-trigger count; this port exists only with the REQ-030 macro.

Function
REQ-014 SHALL implement the states IDLE, ARMED, CAPTURE and READOUT.
REQ-015 IDLE: arm_i=1 SHALL move to ARMED on the next clock; trig_i in IDLE SHALL be ignored.
REQ-016 ARMED: trig_i=1 SHALL write dat_i of that same cycle as sample 0 and move to CAPTURE.
REQ-017 CAPTURE: SHALL write dat_i as samples 1..LENGTH-1 on consecutive clocks with no gaps, then move to READOUT.
REQ-018 Sample k SHALL equal dat_i at cycle T+k, where T is the trigger cycle.
REQ-019 Storage SHALL be a LENGTH x 14 distributed RAM with a $clog2(LENGTH)-bit write address; the address SHALL wrap to 0 after each window.
REQ-020 m_tvalid SHALL first rise exactly 2 clocks after the cycle that writes sample LENGTH-1.
REQ-021 Readout SHALL present samples 0..LENGTH-1 in order, with m_tlast=1 only on sample LENGTH-1.
REQ-022 Handshake: a transfer occurs when m_tvalid and m_tready are both 1; while m_tvalid=1 and m_tready=0, m_tdata, m_tvalid and m_tlast SHALL hold stable.
REQ-023 Throughput: with m_tready held at 1, the block SHALL deliver one sample per clock with no bubbles; prefetch/skid logic is allowed.
REQ-024 After the m_tlast transfer, the block SHALL enter IDLE and deassert m_tvalid on the next clock.
REQ-025 arm_i outside IDLE SHALL be ignored; trig_i outside ARMED SHALL not start a capture.
REQ-026 arm_i and trig_i in the same cycle in IDLE: the arm SHALL be taken and the trigger ignored.
REQ-027 armed_o and busy_o SHALL be registered, decoded from the current state.

Reset
REQ-028 rst_i=1 SHALL force IDLE on the next clock from any state, including mid-CAPTURE and mid-READOUT; RAM contents are not cleared.
REQ-029 Reset values SHALL be: armed_o=0, busy_o=0, m_tvalid=0, m_tlast=0, m_tdata=0, drop_cnt_o=0, read and write addresses 0.

Configuration
REQ-030 With the macro SAMPLE_WINDOW_CAPTURE14_DROP_CNT_EN defined:
  - drop_cnt_o exists;
  - it SHALL increment by one per clock with trig_i=1 in CAPTURE or READOUT;
  - it SHALL saturate at 255;
  - it SHALL be cleared only by rst_i.
REQ-031 Without the macro, the drop_cnt_o port and its counter SHALL be absent, and behaviour on all other ports SHALL be identical.

Verification (LENGTH=8, dat_i = 14'h0100 + cycle index)
REQ-032 Arm, trigger at cycle T with dat_i=14'h0120, m_tready=1 -> m_tvalid rises at T+9; 8 consecutive words 14'h0120..14'h0127; m_tlast on 14'h0127; IDLE at T+17.
REQ-033 Same as REQ-032 with m_tready toggling 1,0,1,0 -> same 8 words in order, outputs stable during stalls, no duplicate or lost words.
REQ-034 trig_i pulses in IDLE, arm_i+trig_i together in IDLE, then trig_i 3 cycles later -> capture starts only at the later trigger; armed_o=1 in between.
REQ-035 rst_i for 1 cycle at capture sample 4, then re-arm and trigger -> m_tvalid stays low until the new window; the new window has correct data.
REQ-036 Macro defined; 300 triggers during CAPTURE/READOUT across windows -> drop_cnt_o reads 255 and holds; rst_i -> 0.
